// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters, plus I->R->C
// prediction tracking. Optional perf counters are enabled by defining BP_PERF_COUNTERS_EN.
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            FlushIR,
  input  logic            FlushRC,
  input  logic [XLEN-1:0] PC_I,
  output logic            Predict,
  output logic [XLEN-1:0] Prediction,
  input  logic            JumpR_R,
  input  logic [XLEN-1:0] PCpImm_R,
  output logic            PredictionCorrect_R,
  input  logic            CtrlValid_C,
  input  logic            Taken_C,
  input  logic [XLEN-1:0] Target_C,
  input  logic [XLEN-1:0] PC_C,
  output logic            PredictionCorrect_C
`ifdef BP_PERF_COUNTERS_EN
  ,
  output logic [31:0]     CtrlCount,
  output logic [31:0]     MispredCount
`endif
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic            valid_q [ENTRIES];
  logic [TAGW-1:0] tag_q   [ENTRIES];
  logic [XLEN-2:0] tgt_q   [ENTRIES];
  logic [1:0]      cnt_q   [ENTRIES];

  logic [IDX-1:0]  idx_i;
  logic [IDX-1:0]  idx_c;
  logic            hit_i;
  logic            hit_c;
  logic            train;

  logic            pred_t_r;
  logic [XLEN-1:0] pred_tgt_r;
  logic            hit_r;
  logic            pred_t_c;
  logic [XLEN-1:0] pred_tgt_c;
  logic            hit_c_q;

  // Fetch lookup: combinational, no bypass from the training port.
  assign idx_i      = PC_I[IDX+1:2];
  assign hit_i      = valid_q[idx_i] && (tag_q[idx_i] == PC_I[XLEN-1:IDX+2]);
  assign Predict    = hit_i && cnt_q[idx_i][1];
  assign Prediction = Predict ? {tgt_q[idx_i], 1'b0} : '0;

  assign idx_c = PC_C[IDX+1:2];
  assign hit_c = valid_q[idx_c] && (tag_q[idx_c] == PC_C[XLEN-1:IDX+2]);
  assign train = CtrlValid_C && !Stall;

  assign PredictionCorrect_R = JumpR_R && pred_t_r && (pred_tgt_r == PCpImm_R);
  assign PredictionCorrect_C = CtrlValid_C && (pred_t_c == Taken_C) &&
                               (!Taken_C || (pred_tgt_c == Target_C));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
      end
    end else if (train) begin
      if (hit_c) begin
        if (Taken_C) begin
          if (cnt_q[idx_c] != 2'b11) cnt_q[idx_c] <= cnt_q[idx_c] + 2'd1;
          tgt_q[idx_c] <= Target_C[XLEN-1:1];
        end else if (cnt_q[idx_c] != 2'b00) begin
          cnt_q[idx_c] <= cnt_q[idx_c] - 2'd1;
        end
      end else if (Taken_C) begin
        // Miss on a taken outcome: overwrite whatever lived at this index.
        valid_q[idx_c] <= 1'b1;
        tag_q[idx_c]   <= PC_C[XLEN-1:IDX+2];
        tgt_q[idx_c]   <= Target_C[XLEN-1:1];
        cnt_q[idx_c]   <= 2'b10;
      end
    end
  end

  // Flushes clear a stage even while the pipeline is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_t_r   <= 1'b0;
      pred_tgt_r <= '0;
      hit_r      <= 1'b0;
      pred_t_c   <= 1'b0;
      pred_tgt_c <= '0;
      hit_c_q    <= 1'b0;
    end else begin
      if (FlushIR) begin
        pred_t_r   <= 1'b0;
        pred_tgt_r <= '0;
        hit_r      <= 1'b0;
      end else if (!Stall) begin
        pred_t_r   <= Predict;
        pred_tgt_r <= Prediction;
        hit_r      <= hit_i;
      end
      if (FlushRC) begin
        pred_t_c   <= 1'b0;
        pred_tgt_c <= '0;
        hit_c_q    <= 1'b0;
      end else if (!Stall) begin
        pred_t_c   <= pred_t_r;
        pred_tgt_c <= pred_tgt_r;
        hit_c_q    <= hit_r;
      end
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CtrlCount    <= '0;
      MispredCount <= '0;
    end else if (train) begin
      CtrlCount <= CtrlCount + 32'd1;
      if (!PredictionCorrect_C) MispredCount <= MispredCount + 32'd1;
    end
  end
`endif

  // PC/target low bits are never indexed and hit_c_q is kept only for observability.
  logic unused_ok;
  assign unused_ok = &{1'b0, PC_I[1:0], PC_C[1:0], Target_C[0], hit_c_q};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed, table-driven bench for branch_target_predictor (ENTRIES=16, XLEN=32),
// with hand-written sequences for mid-operation reset and the optional perf counters.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall, FlushIR, FlushRC;
  logic [31:0] PC_I;
  logic        Predict;
  logic [31:0] Prediction;
  logic        JumpR_R;
  logic [31:0] PCpImm_R;
  logic        PredictionCorrect_R;
  logic        CtrlValid_C, Taken_C;
  logic [31:0] Target_C, PC_C;
  logic        PredictionCorrect_C;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] CtrlCount, MispredCount;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall, fir, frc;
    logic [31:0] pc_i;
    logic        jr;
    logic [31:0] pcpimm;
    logic        cv, tk;
    logic [31:0] tgt, pcc;
    logic        e_p;
    logic [31:0] e_tgt;
    logic        e_pcr, e_pcc;
  } vec_t;

  vec_t vq[$];

  branch_target_predictor #(.ENTRIES(16), .XLEN(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .Stall               (Stall),
    .FlushIR             (FlushIR),
    .FlushRC             (FlushRC),
    .PC_I                (PC_I),
    .Predict             (Predict),
    .Prediction          (Prediction),
    .JumpR_R             (JumpR_R),
    .PCpImm_R            (PCpImm_R),
    .PredictionCorrect_R (PredictionCorrect_R),
    .CtrlValid_C         (CtrlValid_C),
    .Taken_C             (Taken_C),
    .Target_C            (Target_C),
    .PC_C                (PC_C),
    .PredictionCorrect_C (PredictionCorrect_C)
`ifdef BP_PERF_COUNTERS_EN
    ,
    .CtrlCount           (CtrlCount),
    .MispredCount        (MispredCount)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    Stall = 0; FlushIR = 0; FlushRC = 0; PC_I = 0; JumpR_R = 0; PCpImm_R = 0;
    CtrlValid_C = 0; Taken_C = 0; Target_C = 0; PC_C = 0;
  endtask

  task automatic add(input logic stall, input logic fir, input logic frc,
                     input logic [31:0] pc_i, input logic jr, input logic [31:0] pcpimm,
                     input logic cv, input logic tk, input logic [31:0] tgt,
                     input logic [31:0] pcc, input logic e_p, input logic [31:0] e_tgt,
                     input logic e_pcr, input logic e_pcc);
    vec_t v;
    v.stall = stall; v.fir = fir; v.frc = frc; v.pc_i = pc_i; v.jr = jr;
    v.pcpimm = pcpimm; v.cv = cv; v.tk = tk; v.tgt = tgt; v.pcc = pcc;
    v.e_p = e_p; v.e_tgt = e_tgt; v.e_pcr = e_pcr; v.e_pcc = e_pcc;
    vq.push_back(v);
  endtask

  initial begin
    //   stl fir frc pc_i    jr pcpimm  cv tk tgt     pc_c     | P  tgt     pcr pcc
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   0, 'h000, 0, 0); // v0  reset state
    add(0, 0, 0, 'h104, 0, 'h000, 0, 0, 'h000, 'h000,   0, 'h000, 0, 0); // v1
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h180, 'h100,   0, 'h000, 0, 0); // v2  allocate, no bypass
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h180, 0, 0); // v3
    add(0, 0, 0, 'h000, 1, 'h180, 0, 0, 'h000, 'h000,   0, 'h000, 1, 0); // v4  R correct
    add(0, 0, 0, 'h100, 1, 'h180, 1, 1, 'h180, 'h100,   1, 'h180, 0, 1); // v5  cnt 2->3
    add(0, 0, 0, 'h000, 1, 'h184, 0, 0, 'h000, 'h000,   0, 'h000, 0, 0); // v6  wrong R target
    add(0, 0, 0, 'h100, 0, 'h000, 1, 0, 'h000, 'h100,   1, 'h180, 0, 0); // v7  3->2
    add(0, 0, 0, 'h100, 0, 'h000, 1, 0, 'h000, 'h100,   1, 'h180, 0, 1); // v8  2->1
    add(0, 0, 0, 'h100, 0, 'h000, 1, 0, 'h000, 'h100,   0, 'h000, 0, 0); // v9  1->0
    add(0, 0, 0, 'h100, 0, 'h000, 1, 0, 'h000, 'h100,   0, 'h000, 0, 0); // v10 stays 0
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h180, 'h100,   0, 'h000, 0, 0); // v11 0->1
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h180, 'h100,   0, 'h000, 0, 0); // v12 1->2
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h180, 'h100,   1, 'h180, 0, 0); // v13 2->3
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h1c0, 'h100,   1, 'h180, 0, 0); // v14 sat, new tgt
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h180, 'h100,   1, 'h1c0, 0, 1); // v15
    add(0, 0, 0, 'h100, 0, 'h000, 1, 1, 'h180, 'h100,   1, 'h180, 0, 1); // v16
    add(0, 0, 0, 'h100, 0, 'h000, 1, 0, 'h000, 'h100,   1, 'h180, 0, 0); // v17 3->2
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h180, 0, 0); // v18
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h180, 0, 0); // v19
    add(1, 1, 0, 'h000, 1, 'h180, 0, 0, 'h000, 'h000,   0, 'h000, 1, 0); // v20 FlushIR under stall
    add(0, 0, 0, 'h000, 1, 'h180, 0, 0, 'h000, 'h000,   0, 'h000, 0, 0); // v21
    add(0, 0, 0, 'h000, 0, 'h000, 1, 0, 'h000, 'h200,   0, 'h000, 0, 1); // v22 NT miss, correct
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h180, 0, 0); // v23
    add(0, 1, 1, 'h100, 1, 'h180, 0, 0, 'h000, 'h000,   1, 'h180, 1, 0); // v24 both flushes
    add(0, 0, 0, 'h000, 1, 'h180, 1, 0, 'h000, 'h200,   0, 'h000, 0, 1); // v25
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h180, 0, 0); // v26
    add(1, 0, 0, 'h000, 1, 'h180, 0, 0, 'h000, 'h000,   0, 'h000, 1, 0); // v27 stall holds
    add(0, 0, 0, 'h000, 1, 'h180, 0, 0, 'h000, 'h000,   0, 'h000, 1, 0); // v28
    add(0, 0, 0, 'h000, 0, 'h000, 1, 1, 'h180, 'h100,   0, 'h000, 0, 1); // v29 2->3
    add(1, 0, 0, 'h000, 0, 'h000, 1, 0, 'h000, 'h100,   0, 'h000, 0, 1); // v30 stalled, no train
    add(0, 0, 0, 'h000, 0, 'h000, 1, 0, 'h000, 'h100,   0, 'h000, 0, 1); // v31 3->2
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h180, 0, 0); // v32
    add(0, 0, 0, 'h000, 0, 'h000, 1, 1, 'h300, 'h140,   0, 'h000, 0, 0); // v33 alias alloc
    add(0, 0, 0, 'h100, 0, 'h000, 0, 0, 'h000, 'h000,   0, 'h000, 0, 0); // v34 tag mismatch
    add(0, 0, 0, 'h140, 0, 'h000, 0, 0, 'h000, 'h000,   1, 'h300, 0, 0); // v35
    add(0, 0, 0, 'h104, 0, 'h000, 0, 0, 'h000, 'h000,   0, 'h000, 0, 0); // v36

    drive_idle();
    reset = 1'b1;
    #2;
    chk("reset_predict", {31'd0, Predict}, 32'd0);
    chk("reset_prediction", Prediction, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    foreach (vq[i]) begin
      Stall = vq[i].stall; FlushIR = vq[i].fir; FlushRC = vq[i].frc;
      PC_I = vq[i].pc_i; JumpR_R = vq[i].jr; PCpImm_R = vq[i].pcpimm;
      CtrlValid_C = vq[i].cv; Taken_C = vq[i].tk; Target_C = vq[i].tgt; PC_C = vq[i].pcc;
      @(negedge clk);
      chk($sformatf("v%0d_predict", i), {31'd0, Predict}, {31'd0, vq[i].e_p});
      chk($sformatf("v%0d_prediction", i), Prediction, vq[i].e_tgt);
      chk($sformatf("v%0d_correct_r", i), {31'd0, PredictionCorrect_R}, {31'd0, vq[i].e_pcr});
      chk($sformatf("v%0d_correct_c", i), {31'd0, PredictionCorrect_C}, {31'd0, vq[i].e_pcc});
      @(posedge clk); #1;
    end

    // Mid-operation asynchronous reset
    drive_idle();
    PC_I = 'h140;
    @(negedge clk);
    chk("pre_reset_predict", {31'd0, Predict}, 32'd1);
    chk("pre_reset_prediction", Prediction, 32'h300);
    @(posedge clk); #1;
    PC_I = 'h140; JumpR_R = 1; PCpImm_R = 'h300;
    #1;
    chk("pre_reset_correct_r", {31'd0, PredictionCorrect_R}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_reset_predict", {31'd0, Predict}, 32'd0);
    chk("async_reset_prediction", Prediction, 32'd0);
    chk("async_reset_correct_r", {31'd0, PredictionCorrect_R}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    PC_I = 'h140;
    #1;
    chk("post_reset_first_fetch", {31'd0, Predict}, 32'd0);
`ifdef BP_PERF_COUNTERS_EN
    chk("perf_ctrl_reset", CtrlCount, 32'd0);
    chk("perf_mispred_reset", MispredCount, 32'd0);
`endif
    @(posedge clk); #1;

    // Three resolutions (one mispredicted), then one stalled resolution
    drive_idle();
    CtrlValid_C = 1; Taken_C = 1; Target_C = 'h180; PC_C = 'h100;
    @(negedge clk);
    chk("res1_correct_c", {31'd0, PredictionCorrect_C}, 32'd0);
    @(posedge clk); #1;
    Taken_C = 0; Target_C = 0; PC_C = 'h200;
    @(negedge clk);
    chk("res2_correct_c", {31'd0, PredictionCorrect_C}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("res3_correct_c", {31'd0, PredictionCorrect_C}, 32'd1);
    @(posedge clk); #1;
    Stall = 1;
    @(negedge clk);
    chk("res4_stalled_correct_c", {31'd0, PredictionCorrect_C}, 32'd1);
    @(posedge clk); #1;
    drive_idle();
    PC_I = 'h100;
    #1;
    chk("post_reset_alloc_predict", {31'd0, Predict}, 32'd1);
    chk("post_reset_alloc_prediction", Prediction, 32'h180);
`ifdef BP_PERF_COUNTERS_EN
    chk("perf_ctrl_count", CtrlCount, 32'd3);
    chk("perf_mispred_count", MispredCount, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
